// File: rtl/vga_pkg.sv
// Shared definitions for the VGA display pipeline: 640x480@60 timing defaults,
// play-state encodings, colour width and small sizing helpers.
package vga_pkg;

    localparam int COLOUR_W = 12;

    // 640x480@60 with a 25 MHz pixel clock
    localparam int H_VIS_DEF  = 640;
    localparam int H_FP_DEF   = 16;
    localparam int H_SYNC_DEF = 96;
    localparam int H_BP_DEF   = 48;
    localparam int V_VIS_DEF  = 480;
    localparam int V_FP_DEF   = 10;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF   = 33;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2,
        ST_LOSE = 2'd3
    } play_state_e;

    function automatic int h_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

    function automatic int v_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

    // Frame counter runs mod 2*flash_frames; keep at least 4 bits for the WIN tint nibble
    function automatic int frame_cnt_w(input int flash_frames);
        int w;
        w = $clog2(2 * flash_frames);
        return (w < 4) ? 4 : w;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-enable divider, line/frame counters, frame counter and the registered
// address / visible / raw sync decode for one pixel.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int H_VIS        = H_VIS_DEF,
    parameter int H_FP         = H_FP_DEF,
    parameter int H_SYNC       = H_SYNC_DEF,
    parameter int H_BP         = H_BP_DEF,
    parameter int V_VIS        = V_VIS_DEF,
    parameter int V_FP         = V_FP_DEF,
    parameter int V_SYNC       = V_SYNC_DEF,
    parameter int V_BP         = V_BP_DEF,
    parameter bit HS_POL       = 1'b0,
    parameter bit VS_POL       = 1'b0,
    parameter int FLASH_FRAMES = 30,
    parameter int AH_W         = 10,
    parameter int AV_W         = 9
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    output logic                                  pe,
    output logic                                  frame_wrap,
    output logic [AH_W-1:0]                       addr_h,
    output logic [AV_W-1:0]                       addr_v,
    output logic                                  vis,
    output logic                                  hs,
    output logic                                  vs,
    output logic                                  frame_tick,
    output logic [frame_cnt_w(FLASH_FRAMES)-1:0]  frame_cnt
);

    localparam int H_TOTAL  = h_total(H_VIS, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL  = v_total(V_VIS, V_FP, V_SYNC, V_BP);
    localparam int HC_W     = $clog2(H_TOTAL);
    localparam int VC_W     = $clog2(V_TOTAL);
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FC_W     = frame_cnt_w(FLASH_FRAMES);
    localparam int HS_START = H_VIS + H_FP;
    localparam int HS_END   = H_VIS + H_FP + H_SYNC;
    localparam int VS_START = V_VIS + V_FP;
    localparam int VS_END   = V_VIS + V_FP + V_SYNC;

    logic [DIV_W-1:0] div_reg;
    logic [HC_W-1:0]  hcnt_reg;
    logic [VC_W-1:0]  vcnt_reg;
    logic [FC_W-1:0]  frame_cnt_reg;
    logic [AH_W-1:0]  addr_h_reg;
    logic [AV_W-1:0]  addr_v_reg;
    logic             vis_reg;
    logic             hs_reg;
    logic             vs_reg;
    logic             frame_tick_reg;

    logic h_wrap;
    logic v_wrap;
    logic visible_now;
    logic hs_active;
    logic vs_active;

    assign pe          = (div_reg == DIV_W'(CLK_DIV - 1));
    assign h_wrap      = (hcnt_reg == HC_W'(H_TOTAL - 1));
    assign v_wrap      = (vcnt_reg == VC_W'(V_TOTAL - 1));
    assign frame_wrap  = pe && h_wrap && v_wrap;
    // Decode in 32-bit so sync windows touching H_TOTAL/V_TOTAL never overflow
    assign visible_now = (int'(hcnt_reg) < H_VIS) && (int'(vcnt_reg) < V_VIS);
    assign hs_active   = (int'(hcnt_reg) >= HS_START) && (int'(hcnt_reg) < HS_END);
    assign vs_active   = (int'(vcnt_reg) >= VS_START) && (int'(vcnt_reg) < VS_END);

    // Clock divider producing one pixel enable every CLK_DIV cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg <= '0;
        end else if (pe) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + 1'b1;
        end
    end

    // Horizontal, vertical and frame counters advanced on each pixel enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_reg      <= '0;
            vcnt_reg      <= '0;
            frame_cnt_reg <= '0;
        end else if (pe) begin
            if (h_wrap) begin
                hcnt_reg <= '0;
                if (v_wrap) begin
                    vcnt_reg      <= '0;
                    frame_cnt_reg <= (frame_cnt_reg == FC_W'(2 * FLASH_FRAMES - 1)) ?
                                     '0 : frame_cnt_reg + 1'b1;
                end else begin
                    vcnt_reg <= vcnt_reg + 1'b1;
                end
            end else begin
                hcnt_reg <= hcnt_reg + 1'b1;
            end
        end
    end

    // Register address, visibility and sync for the pixel the counters point at
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_h_reg     <= '0;
            addr_v_reg     <= '0;
            vis_reg        <= 1'b0;
            hs_reg         <= ~HS_POL;
            vs_reg         <= ~VS_POL;
            frame_tick_reg <= 1'b0;
        end else begin
            frame_tick_reg <= frame_wrap;
            if (pe) begin
                addr_h_reg <= visible_now ? AH_W'(hcnt_reg) : '0;
                addr_v_reg <= visible_now ? AV_W'(vcnt_reg) : '0;
                vis_reg    <= visible_now;
                hs_reg     <= hs_active ? HS_POL : ~HS_POL;
                vs_reg     <= vs_active ? VS_POL : ~VS_POL;
            end
        end
    end

    assign addr_h     = addr_h_reg;
    assign addr_v     = addr_v_reg;
    assign vis        = vis_reg;
    assign hs         = hs_reg;
    assign vs         = vs_reg;
    assign frame_tick = frame_tick_reg;
    assign frame_cnt  = frame_cnt_reg;

endmodule

// File: rtl/vga_display_pipeline.sv
// VGA timing plus colour pipeline: waits out the frame-buffer read latency,
// applies the per-frame play-state colour mode, blanks, and registers
// COLOUR_OUT together with HS/VS so all three stay pixel-aligned.
// RESETn is expected to be released synchronously to CLK by the system.
module vga_display_pipeline
    import vga_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int H_VIS        = H_VIS_DEF,
    parameter int H_FP         = H_FP_DEF,
    parameter int H_SYNC       = H_SYNC_DEF,
    parameter int H_BP         = H_BP_DEF,
    parameter int V_VIS        = V_VIS_DEF,
    parameter int V_FP         = V_FP_DEF,
    parameter int V_SYNC       = V_SYNC_DEF,
    parameter int V_BP         = V_BP_DEF,
    parameter bit HS_POL       = 1'b0,
    parameter bit VS_POL       = 1'b0,
    parameter int MEM_LAT      = 1,
    parameter int FLASH_FRAMES = 30,
    parameter int AH_W         = 10,
    parameter int AV_W         = 9
) (
    input  logic                CLK,
    input  logic                RESETn,
    input  logic [COLOUR_W-1:0] COLOUR_IN,
    input  logic [1:0]          PLAY_STATE,
    output logic [AH_W-1:0]     ADDRH,
    output logic [AV_W-1:0]     ADDRV,
    output logic [COLOUR_W-1:0] COLOUR_OUT,
    output logic                HS,
    output logic                VS,
    output logic                FRAME_TICK
);

    localparam int FC_W = frame_cnt_w(FLASH_FRAMES);

    logic            pe;
    logic            frame_wrap;
    logic            vis;
    logic            hs_raw;
    logic            vs_raw;
    logic [FC_W-1:0] frame_cnt;

    logic [MEM_LAT:0]    pe_pipe_reg;
    play_state_e         play_state_reg;
    logic [COLOUR_W-1:0] colour_mode;
    logic [COLOUR_W-1:0] colour_out_reg;
    logic                hs_out_reg;
    logic                vs_out_reg;
    logic                capture;

    vga_timing_gen #(
        .CLK_DIV      (CLK_DIV),
        .H_VIS        (H_VIS),
        .H_FP         (H_FP),
        .H_SYNC       (H_SYNC),
        .H_BP         (H_BP),
        .V_VIS        (V_VIS),
        .V_FP         (V_FP),
        .V_SYNC       (V_SYNC),
        .V_BP         (V_BP),
        .HS_POL       (HS_POL),
        .VS_POL       (VS_POL),
        .FLASH_FRAMES (FLASH_FRAMES),
        .AH_W         (AH_W),
        .AV_W         (AV_W)
    ) u_timing (
        .clk        (CLK),
        .rst_n      (RESETn),
        .pe         (pe),
        .frame_wrap (frame_wrap),
        .addr_h     (ADDRH),
        .addr_v     (ADDRV),
        .vis        (vis),
        .hs         (hs_raw),
        .vs         (vs_raw),
        .frame_tick (FRAME_TICK),
        .frame_cnt  (frame_cnt)
    );

    // Delay the pixel enable so capture lands MEM_LAT+1 cycles after the address edge.
    // vis/hs_raw/vs_raw are held for a whole pixel, so they are still the values
    // belonging to this address when capture fires (CLK_DIV >= MEM_LAT+1).
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            pe_pipe_reg <= '0;
        end else begin
            pe_pipe_reg[0] <= pe;
            for (int i = 1; i <= MEM_LAT; i++) begin
                pe_pipe_reg[i] <= pe_pipe_reg[i-1];
            end
        end
    end

    assign capture = pe_pipe_reg[MEM_LAT];

    // Latch the play state only at the frame wrap so a frame never changes mode mid-way
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            play_state_reg <= ST_IDLE;
        end else if (frame_wrap) begin
            play_state_reg <= play_state_e'(PLAY_STATE);
        end
    end

    // Colour mode: pass-through, red tint by frame count, or inverted half of the LOSE flash
    always_comb begin
        colour_mode = COLOUR_IN;
        case (play_state_reg)
            ST_WIN:  colour_mode = COLOUR_IN ^ {frame_cnt[3:0], 8'h00};
            ST_LOSE: begin
                if (frame_cnt >= FC_W'(FLASH_FRAMES)) begin
                    colour_mode = ~COLOUR_IN;
                end
            end
            default: colour_mode = COLOUR_IN;
        endcase
    end

    // Output registers: colour (blanked outside the visible area) and sync on one edge
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            colour_out_reg <= '0;
            hs_out_reg     <= ~HS_POL;
            vs_out_reg     <= ~VS_POL;
        end else if (capture) begin
            colour_out_reg <= vis ? colour_mode : '0;
            hs_out_reg     <= hs_raw;
            vs_out_reg     <= vs_raw;
        end
    end

    assign COLOUR_OUT = colour_out_reg;
    assign HS         = hs_out_reg;
    assign VS         = vs_out_reg;

endmodule

// File: tb/tb_vga_display_pipeline.sv
// Bench for vga_display_pipeline with a shrunken raster. A pixel-index model
// (edge count since reset release -> pixel -> x/y/frame) predicts every output
// on every falling edge; a vector table and a few sequences cover corner cases.
module tb_vga_display_pipeline;

    localparam int CD   = 4;
    localparam int ML   = 1;
    localparam int HV   = 8;
    localparam int HF   = 2;
    localparam int HSY  = 3;
    localparam int HB   = 2;
    localparam int VV   = 6;
    localparam int VF   = 1;
    localparam int VSY  = 2;
    localparam int VB   = 1;
    localparam int FF   = 3;
    localparam int HT   = HV + HF + HSY + HB;   // 15
    localparam int VT   = VV + VF + VSY + VB;   // 10
    localparam int NPIX = HT * VT;              // 150 pixels, 600 clocks per frame

    logic        clk;
    logic        rst_n;
    logic [11:0] colour_in;
    logic [1:0]  play_state;
    logic [9:0]  addrh;
    logic [8:0]  addrv;
    logic [11:0] colour_out;
    logic        hs;
    logic        vs;
    logic        frame_tick;

    logic [11:0] mem [0:15][0:15];
    int          frame_state [0:63];
    int          t;
    int          checks;
    int          errors;
    bit          chk_en;

    typedef struct {
        string       name;
        int          t;
        logic [11:0] col;
        logic        hs;
        logic        vs;
        int          ah;
        int          av;
        logic        tick;
    } vec_t;

    vec_t vecs [17];

    vga_display_pipeline #(
        .CLK_DIV(CD), .H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .MEM_LAT(ML), .FLASH_FRAMES(FF),
        .AH_W(10), .AV_W(9)
    ) dut (
        .CLK(clk), .RESETn(rst_n), .COLOUR_IN(colour_in), .PLAY_STATE(play_state),
        .ADDRH(addrh), .ADDRV(addrv), .COLOUR_OUT(colour_out),
        .HS(hs), .VS(vs), .FRAME_TICK(frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Frame-buffer model: one-cycle registered read of the bench's image
    always @(posedge clk) colour_in <= mem[addrh[3:0]][addrv[3:0]];

    // Edge counter since release, and the play state seen at each frame wrap
    initial begin
        t = 0;
        forever begin
            @(posedge clk);
            if (rst_n) begin
                t++;
                if (t % (CD * NPIX) == 0 && t / (CD * NPIX) < 64)
                    frame_state[t / (CD * NPIX)] = int'(play_state);
            end else begin
                t = 0;
                frame_state[0] = 0;
            end
        end
    end

    function automatic void model(input int tt, output logic [11:0] e_col, output logic e_hs,
                                  output logic e_vs, output int e_ah, output int e_av,
                                  output logic e_tick);
        int n, m, x, y, f, fc, st;
        logic [11:0] c;
        e_col = 12'h000; e_hs = 1'b1; e_vs = 1'b1; e_ah = 0; e_av = 0;
        e_tick = (tt > 0) && (tt % (CD * NPIX) == 0);
        if (tt >= CD) begin
            m = tt / CD - 1;
            x = m % HT;
            y = (m / HT) % VT;
            if (x < HV && y < VV) begin
                e_ah = x;
                e_av = y;
            end
        end
        if (tt >= ML + 1 + CD) begin
            n  = (tt - ML - 1) / CD - 1;
            x  = n % HT;
            y  = (n / HT) % VT;
            f  = n / NPIX;
            fc = f % (2 * FF);
            e_hs = !(x >= HV + HF && x < HV + HF + HSY);
            e_vs = !(y >= VV + VF && y < VV + VF + VSY);
            if (x < HV && y < VV) begin
                c  = mem[x][y];
                st = (f < 64) ? frame_state[f] : 0;
                if (st == 2) c = c ^ 12'(fc << 8);
                else if (st == 3 && fc >= FF) c = ~c;
                e_col = c;
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d actual=%0h expected=%0h", name, t, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [11:0] e_col, input logic e_hs,
                             input logic e_vs, input int e_ah, input int e_av, input logic e_tick);
        check({tag, ".colour"}, 32'(colour_out), 32'(e_col));
        check({tag, ".hs"},     32'(hs),         32'(e_hs));
        check({tag, ".vs"},     32'(vs),         32'(e_vs));
        check({tag, ".addrh"},  32'(addrh),      32'(e_ah));
        check({tag, ".addrv"},  32'(addrv),      32'(e_av));
        check({tag, ".tick"},   32'(frame_tick), 32'(e_tick));
    endtask

    task automatic wait_t(input int target);
        int guard;
        guard = 0;
        while (t < target && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (t < target) check("wait_timeout", 32'(t), 32'(target));
    endtask

    // Continuous comparison against the pixel model on every falling edge
    initial begin
        logic [11:0] e_col;
        logic e_hs, e_vs, e_tick;
        int e_ah, e_av;
        forever begin
            @(negedge clk);
            if (chk_en && rst_n) begin
                model(t, e_col, e_hs, e_vs, e_ah, e_av, e_tick);
                check_all("model", e_col, e_hs, e_vs, e_ah, e_av, e_tick);
            end
        end
    end

    task automatic random_states_until(input int t_end);
        while (t < t_end) begin
            repeat ($urandom_range(40, 300)) @(negedge clk);
            play_state = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic pulse_reset_mid_line(input int fill_mode, input logic [1:0] st_after);
        int guard;
        guard = 0;
        while (((t / CD - 1) % NPIX) != 50 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("reset_point_reached", 32'(((t / CD - 1) % NPIX) == 50), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_all("async_reset", 12'h000, 1'b1, 1'b1, 0, 0, 1'b0);
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                mem[x][y] = (fill_mode == 0) ? 12'($urandom) : 12'h000;
        play_state = st_after;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        chk_en = 1'b0;
        rst_n = 1'b0;
        play_state = 2'd0;
        for (int i = 0; i < 64; i++) frame_state[i] = 0;
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                mem[x][y] = {4'(x), 4'(y), 4'hF};

        // name, t, colour, hs, vs, addrh, addrv, tick  (frame 0, IDLE, pattern image)
        vecs[0]  = '{"just_released",  1,   12'h000, 1'b1, 1'b1, 0, 0, 1'b0};
        vecs[1]  = '{"pix_0_0",        6,   12'h00F, 1'b1, 1'b1, 0, 0, 1'b0};
        vecs[2]  = '{"addr_1_0",       8,   12'h00F, 1'b1, 1'b1, 1, 0, 1'b0};
        vecs[3]  = '{"pix_5_0",        26,  12'h50F, 1'b1, 1'b1, 5, 0, 1'b0};
        vecs[4]  = '{"hblank_8",       38,  12'h000, 1'b1, 1'b1, 0, 0, 1'b0};
        vecs[5]  = '{"pre_hsync",      45,  12'h000, 1'b1, 1'b1, 0, 0, 1'b0};
        vecs[6]  = '{"hsync_start",    46,  12'h000, 1'b0, 1'b1, 0, 0, 1'b0};
        vecs[7]  = '{"hsync_last",     57,  12'h000, 1'b0, 1'b1, 0, 0, 1'b0};
        vecs[8]  = '{"hsync_end",      58,  12'h000, 1'b1, 1'b1, 0, 0, 1'b0};
        vecs[9]  = '{"pix_5_3",        206, 12'h53F, 1'b1, 1'b1, 5, 3, 1'b0};
        vecs[10] = '{"pix_7_5_last",   334, 12'h75F, 1'b1, 1'b1, 7, 5, 1'b0};
        vecs[11] = '{"vblank_row6",    366, 12'h000, 1'b1, 1'b1, 0, 0, 1'b0};
        vecs[12] = '{"vsync_row7",     426, 12'h000, 1'b1, 1'b0, 0, 0, 1'b0};
        vecs[13] = '{"vsync_end_row9", 546, 12'h000, 1'b1, 1'b1, 0, 0, 1'b0};
        vecs[14] = '{"frame_tick",     600, 12'h000, 1'b1, 1'b1, 0, 0, 1'b1};
        vecs[15] = '{"tick_one_clk",   601, 12'h000, 1'b1, 1'b1, 0, 0, 1'b0};
        vecs[16] = '{"frame1_pix_0_0", 606, 12'h00F, 1'b1, 1'b1, 0, 0, 1'b0};

        repeat (3) @(negedge clk);
        check_all("in_reset", 12'h000, 1'b1, 1'b1, 0, 0, 1'b0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        foreach (vecs[i]) begin
            wait_t(vecs[i].t);
            check_all(vecs[i].name, vecs[i].col, vecs[i].hs, vecs[i].vs,
                      vecs[i].ah, vecs[i].av, vecs[i].tick);
        end

        // Random play-state changes at arbitrary points inside frames
        random_states_until(3 * CD * NPIX);

        // LOSE asserted mid-frame, held across a full flash period and a bit more
        repeat ($urandom_range(50, 400)) @(negedge clk);
        play_state = 2'd3;
        wait_t(t + 7 * CD * NPIX);

        // Async reset in the middle of a visible line, random image afterwards
        pulse_reset_mid_line(0, 2'($urandom_range(0, 3)));
        random_states_until(3 * CD * NPIX);

        // WIN over a black image: red nibble tracks the frame counter
        pulse_reset_mid_line(1, 2'd2);
        wait_t(4 * (3 * NPIX + 2 * HT + 2 + 1) + 2);
        check("win_tint_f3_pix_2_2", 32'(colour_out), 32'h300);
        wait_t(4 * (4 * NPIX + 2 * HT + 9 + 1) + 2);
        check("win_blank_f4_pix_9_2", 32'(colour_out), 32'h000);
        wait_t(8 * CD * NPIX);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
